mem_arbiter: RTL and testbench

- Sequences the single byte-wide unified RAM port and shares it between the instruction-fetch path (fed by the PC register) and the MEM-stage load/store path.
- Serialises each 1/2/4-byte access into consecutive byte cycles and assembles or disassembles little-endian words.
- Reports completion to each requester; the pipeline stall controller turns a pending-but-not-done request into stall_state bits.
- Lets an EX-stage branch abort an in-flight fetch.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial unified RAM arbiter.
// State encodings are 3 bits wide; access lengths follow the MEM-stage encoding.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_t;

  localparam logic [1:0] MEM_LEN_BYTE = 2'b00;
  localparam logic [1:0] MEM_LEN_HALF = 2'b01;
  localparam logic [1:0] MEM_LEN_WORD = 2'b10;

  // Length code 11 is treated as a word access.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      MEM_LEN_BYTE: len_to_bytes = 3'd1;
      MEM_LEN_HALF: len_to_bytes = 3'd2;
      default:      len_to_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the byte-wide unified RAM port between instruction fetch and load/store,
// serialising 1/2/4-byte little-endian accesses into consecutive byte cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  input  logic                  if_flush_i,
  output logic [31:0]           if_data_o,
  output logic                  if_done_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_len_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_done_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  arb_state_t state_q, next_state;

  logic [2:0]            cnt_q;
  logic [2:0]            n_q;
  logic [RAM_ADDR_W-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           asm_q;

  logic                  accept_mem;
  logic                  accept_if;
  logic [31:0]           asm_next;
  logic [7:0]            wr_byte_next;
  logic [RAM_ADDR_W-1:0] addr_next;

  // Wrapping modulo 2^32 and then truncating equals wrapping modulo 2^RAM_ADDR_W,
  // so only the low address bits are ever kept.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr_i[31:RAM_ADDR_W], mem_addr_i[31:RAM_ADDR_W]};

  assign addr_next = base_q + RAM_ADDR_W'(cnt_q) + RAM_ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          accept_mem = 1'b1;
          next_state = mem_we_i ? ST_MEM_WR : ST_MEM_RD;
        end else if (if_req_i && !if_flush_i) begin
          accept_if  = 1'b1;
          next_state = ST_IF_RD;
        end
      end
      ST_IF_RD: begin
        if (if_flush_i)          next_state = ST_IDLE;
        else if (cnt_q == n_q)   next_state = ST_DONE;
      end
      ST_MEM_RD: begin
        if (cnt_q == n_q)        next_state = ST_DONE;
      end
      ST_MEM_WR: begin
        if (cnt_q == n_q - 3'd1) next_state = ST_DONE;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // The byte addressed in cycle k arrives during cycle k+1, so in cycle c the
  // RAM is returning byte c-1.
  always_comb begin
    asm_next = asm_q;
    case (cnt_q)
      3'd1:    asm_next[7:0]   = ram_din_i;
      3'd2:    asm_next[15:8]  = ram_din_i;
      3'd3:    asm_next[23:16] = ram_din_i;
      3'd4:    asm_next[31:24] = ram_din_i;
      default: asm_next = asm_q;
    endcase
  end

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    wr_byte_next = wdata_q[15:8];
      2'd1:    wr_byte_next = wdata_q[23:16];
      default: wr_byte_next = wdata_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      n_q         <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      if_data_o   <= '0;
      if_done_o   <= 1'b0;
      mem_rdata_o <= '0;
      mem_done_o  <= 1'b0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= '0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q      <= '0;
          asm_q      <= '0;
          ram_wr_o   <= 1'b0;
          ram_addr_o <= '0;
          if (accept_mem) begin
            base_q     <= mem_addr_i[RAM_ADDR_W-1:0];
            n_q        <= len_to_bytes(mem_len_i);
            wdata_q    <= mem_wdata_i;
            ram_addr_o <= mem_addr_i[RAM_ADDR_W-1:0];
            if (mem_we_i) begin
              ram_wr_o   <= 1'b1;
              ram_dout_o <= mem_wdata_i[7:0];
            end
          end else if (accept_if) begin
            base_q     <= if_addr_i[RAM_ADDR_W-1:0];
            n_q        <= 3'd4;
            ram_addr_o <= if_addr_i[RAM_ADDR_W-1:0];
          end
        end
        ST_IF_RD, ST_MEM_RD: begin
          cnt_q <= cnt_q + 3'd1;
          asm_q <= asm_next;
          if (next_state == ST_IDLE) begin
            asm_q      <= '0;
            ram_addr_o <= '0;
          end else if (next_state == ST_DONE) begin
            ram_addr_o <= '0;
            if (state_q == ST_IF_RD) begin
              if_done_o <= 1'b1;
              if_data_o <= asm_next;
            end else begin
              mem_done_o  <= 1'b1;
              mem_rdata_o <= asm_next;
            end
          end else if (cnt_q < n_q - 3'd1) begin
            ram_addr_o <= addr_next;
          end
        end
        ST_MEM_WR: begin
          cnt_q <= cnt_q + 3'd1;
          if (next_state == ST_DONE) begin
            ram_wr_o   <= 1'b0;
            ram_addr_o <= '0;
            mem_done_o <= 1'b1;
          end else begin
            ram_addr_o <= addr_next;
            ram_dout_o <= wr_byte_next;
          end
        end
        ST_DONE: begin
          cnt_q      <= '0;
          ram_wr_o   <= 1'b0;
          ram_addr_o <= '0;
        end
        default: begin
          ram_wr_o   <= 1'b0;
          ram_addr_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and random traffic checked against a byte-level memory model.
module tb_mem_arbiter;

  localparam int AW       = 17;
  localparam int RAM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, if_flush_i, mem_req_i, mem_we_i;
  logic [31:0]   if_addr_i, mem_addr_i, mem_wdata_i;
  logic [1:0]    mem_len_i;
  logic [31:0]   if_data_o, mem_rdata_o;
  logic          if_done_o, mem_done_o, ram_wr_o;
  logic [AW-1:0] ram_addr_o;
  logic [7:0]    ram_dout_o, ram_din_i;

  logic          mem_init, pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;
  logic [7:0]    ram    [RAM_SIZE];
  logic [7:0]    shadow [RAM_SIZE];

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_cycle;
    string       name;
  } vec_t;

  always #5 clk = ~clk;

  mem_arbiter #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o),
    .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  function automatic logic [7:0] seed_byte(input int i);
    logic [31:0] v;
    v = (i * 37) ^ (i >> 7) ^ 32'h5A;
    return v[7:0];
  endfunction

  // Synchronous-read RAM: data for the address seen at an edge appears after it.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < RAM_SIZE; i++) ram[i] <= seed_byte(i);
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (ram_wr_o) begin
      ram[ram_addr_o] <= ram_dout_o;
    end
    ram_din_i <= ram[ram_addr_o];
  end

  function automatic logic [AW-1:0] ram_index(input logic [31:0] addr, input int k);
    logic [31:0] a;
    a = addr + 32'(k);
    return a[AW-1:0];
  endfunction

  function automatic int n_bytes(input bit is_if, input logic [1:0] len);
    if (is_if) return 4;
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d = d | (32'(shadow[ram_index(addr, k)]) << (8 * k));
    return d;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    shadow[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic drop_requests();
    if_req_i   = 1'b0;
    mem_req_i  = 1'b0;
    mem_we_i   = 1'b0;
    if_flush_i = 1'b0;
  endtask

  // One complete transaction; called at a negedge, returns at a negedge.
  task automatic apply_stimulus(input vec_t v);
    int          n;
    int          done_c;
    bit          seq_ok;
    bit          is_wr;
    logic [31:0] got;
    n      = n_bytes(v.is_if, v.len);
    is_wr  = v.we && !v.is_if;
    done_c = -1;
    seq_ok = 1'b1;
    got    = '0;
    if (v.is_if) begin
      if_req_i  = 1'b1;
      if_addr_i = v.addr;
    end else begin
      mem_req_i   = 1'b1;
      mem_we_i    = v.we;
      mem_len_i   = v.len;
      mem_addr_i  = v.addr;
      mem_wdata_i = v.wdata;
    end
    @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ram_wr_o !== (is_wr && c < n)) seq_ok = 1'b0;
      if (c < n) begin
        if (ram_addr_o !== ram_index(v.addr, c)) seq_ok = 1'b0;
        if (is_wr && ram_dout_o !== 8'(v.wdata >> (8 * c))) seq_ok = 1'b0;
      end
      if (v.is_if ? mem_done_o : if_done_o) seq_ok = 1'b0;
      if (v.is_if ? if_done_o : mem_done_o) begin
        done_c = c;
        got    = v.is_if ? if_data_o : mem_rdata_o;
        break;
      end
    end
    check_output({v.name, "_done_cycle"}, 32'(done_c), 32'(v.exp_cycle));
    check_output({v.name, "_ram_sequence"}, 32'(seq_ok), 32'd1);
    if (!is_wr) check_output({v.name, "_data"}, got, v.exp_data);
    // Request is still held through the DONE edge; it must not be re-accepted.
    @(negedge clk);
    check_output({v.name, "_idle_after_done"},
                 {12'd0, ram_addr_o, ram_wr_o, if_done_o, mem_done_o}, 32'd0);
    drop_requests();
    if (is_wr)
      for (int k = 0; k < n; k++) shadow[ram_index(v.addr, k)] = 8'(v.wdata >> (8 * k));
  endtask

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    int          mem_c, if_c, if_pulses, mem_pulses, diffs;
    logic [31:0] got_mem, got_if, exp_if;

    rst = 1'b0; mem_init = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_len_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    for (int i = 0; i < RAM_SIZE; i++) shadow[i] = seed_byte(i);
    @(negedge clk);
    mem_init = 1'b0;

    preload(17'h00004, 8'h13); preload(17'h00005, 8'h00);
    preload(17'h00006, 8'h50); preload(17'h00007, 8'h00);
    preload(17'h00020, 8'hFF);
    preload(17'h01000, 8'h11); preload(17'h01003, 8'h44);
    preload(17'h1FFFE, 8'hA1); preload(17'h1FFFF, 8'hA2);
    preload(17'h00000, 8'hA3); preload(17'h00001, 8'hA4);

    check_output("reset_if_data", if_data_o, 32'd0);
    check_output("reset_mem_rdata", mem_rdata_o, 32'd0);
    check_output("reset_ram_ctrl",
                 {4'd0, ram_dout_o, ram_addr_o, ram_wr_o, if_done_o, mem_done_o}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vectors: {is_if, we, len, addr, wdata, expected data, done cycle}
    vecs.push_back('{1, 0, 2'b10, 32'h0000_0004, 32'h0, 32'h0050_0013, 5, "word_fetch"});
    vecs.push_back('{0, 0, 2'b00, 32'h0000_0020, 32'h0, 32'h0000_00FF, 2, "load_byte"});
    vecs.push_back('{0, 1, 2'b01, 32'h0000_1001, 32'hAABB_CCDD, 32'h0, 2, "store_half"});
    vecs.push_back('{0, 0, 2'b01, 32'h0000_1001, 32'h0, 32'h0000_CCDD, 3, "load_half"});
    vecs.push_back('{0, 0, 2'b10, 32'h0000_1000, 32'h0, 32'h44CC_DD11, 5, "load_word"});
    vecs.push_back('{0, 0, 2'b10, 32'h0001_FFFE, 32'h0, 32'hA4A3_A2A1, 5, "truncation"});
    vecs.push_back('{0, 1, 2'b11, 32'hFFFF_FFFF, 32'h0102_0304, 32'h0, 4, "store_wrap"});
    vecs.push_back('{0, 0, 2'b10, 32'h0001_FFFF, 32'h0, 32'h0102_0304, 5, "load_wrap"});
    vecs.push_back('{0, 0, 2'b00, 32'h0000_1003, 32'h0, 32'h0000_0044, 2, "half_no_spill"});
    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Simultaneous requests: load wins, fetch follows after DONE and IDLE.
    mem_c = -1; if_c = -1; got_mem = '0; got_if = '0;
    exp_if = model_read(32'h10, 4);
    if_req_i = 1'b1; if_addr_i = 32'h10;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h20;
    @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_done_o) begin mem_c = c; got_mem = mem_rdata_o; mem_req_i = 1'b0; end
      if (if_done_o) begin if_c = c; got_if = if_data_o; break; end
    end
    drop_requests();
    check_output("simul_mem_cycle", 32'(mem_c), 32'd2);
    check_output("simul_mem_data", got_mem, 32'h0000_00FF);
    check_output("simul_if_cycle", 32'(if_c), 32'd9);
    check_output("simul_if_data", got_if, exp_if);
    @(negedge clk);

    // Branch flush in cycle 2 of a fetch at 0x8, then a fetch at the target.
    if_pulses = 0; if_c = -1; got_if = '0;
    exp_if = model_read(32'h40, 4);
    if_req_i = 1'b1; if_addr_i = 32'h8;
    @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 2) if_flush_i = 1'b1;
      if (c == 3) begin
        if_flush_i = 1'b0;
        if_addr_i  = 32'h40;
        check_output("flush_idle_addr", 32'(ram_addr_o), 32'd0);
      end
      if (if_done_o) begin
        if_pulses++;
        if (if_c < 0) begin if_c = c; got_if = if_data_o; end
        if_req_i = 1'b0;
      end
      if (c == 12) break;
    end
    drop_requests();
    check_output("flush_done_pulses", 32'(if_pulses), 32'd1);
    check_output("flush_target_cycle", 32'(if_c), 32'd9);
    check_output("flush_target_data", got_if, exp_if);

    // Reset asserted during cycle 1 of a word store.
    mem_pulses = 0;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'b10;
    mem_addr_i = 32'h3000; mem_wdata_i = 32'h5566_7788;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_done_o) mem_pulses++;
      if (c == 1) rst = 1'b0;
      if (c == 2)
        check_output("reset_mid_store_outputs",
                     {4'd0, ram_dout_o, ram_addr_o, ram_wr_o, if_done_o, mem_done_o} |
                     if_data_o | mem_rdata_o, 32'd0);
      if (c == 3) begin rst = 1'b1; drop_requests(); end
    end
    check_output("reset_no_done", 32'(mem_pulses), 32'd0);
    shadow[17'h3000] = 8'h88;
    shadow[17'h3001] = 8'h77;
    v = '{0, 0, 2'b10, 32'h3000, 32'h0, 32'h0, 5, "after_reset_load"};
    v.exp_data = model_read(32'h3000, 4);
    apply_stimulus(v);

    // Random traffic against the memory model.
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind       = $urandom_range(0, 2);
      v.is_if    = (kind == 0);
      v.we       = (kind == 2);
      v.len      = 2'($urandom_range(0, 3));
      v.addr     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                               : $urandom;
      v.wdata    = $urandom;
      v.name     = $sformatf("rand%0d", i);
      v.exp_cycle = v.we ? n_bytes(v.is_if, v.len) : n_bytes(v.is_if, v.len) + 1;
      v.exp_data = v.we ? 32'h0 : model_read(v.addr, n_bytes(v.is_if, v.len));
      apply_stimulus(v);
    end

    @(negedge clk);
    diffs = 0;
    for (int i = 0; i < RAM_SIZE; i++) if (ram[i] !== shadow[i]) diffs++;
    check_output("ram_contents", 32'(diffs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
